y_pulse_counter: RTL

Y_PULSE_COUNTER -- requirements
Module: y_pulse_counter

---
 rtl/y_pulse_counter.sv | 88 ++++++++
 1 files changed

// File: rtl/y_pulse_counter.sv
// Debounced rise/fall detector for an asynchronous gate output, with a
// saturating rise-event counter and a sticky saturation flag.
module y_pulse_counter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             en,
  input  logic             clr,
  output logic             y_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int unsigned           STAB_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic              s1_q, s2_q;
  logic              y_filt_q, y_filt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sat_q, sat_d;
  logic              accept;
  logic              rise_evt;

  always_comb begin
    y_filt_d = y_filt_q;
    stab_d   = '0;
    accept   = 1'b0;
    // stab only advances while s2 disagrees with the filtered level
    if (s2_q != y_filt_q) begin
      if (stab_q == STAB_LAST) begin
        accept   = 1'b1;
        y_filt_d = s2_q;
      end else begin
        stab_d = stab_q + STAB_W'(1);
      end
    end
    rise_evt = accept & s2_q;
    rise_d   = rise_evt;
    fall_d   = accept & ~s2_q;

    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (en && rise_evt && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
      sat_d   = &count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      y_filt_q <= 1'b0;
      stab_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      s1_q     <= y_in;
      s2_q     <= s1_q;
      y_filt_q <= y_filt_d;
      stab_q   <= stab_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  assign y_filt     = y_filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign count      = count_q;
  assign sat        = sat_q;

endmodule
